dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-port 64-bit data memory (256 words, word-indexed address, synchronous write, registered read with 1-cycle latency).
- Port 0 serves the core load/store unit; port 1 serves a secondary master (debug/DMA loader).
- Each port uses a valid/ready request channel and a one-cycle response pulse.
- Requests with an out-of-range address are rejected with an error response and never reach memory.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response channels of both ports plus the memory-side bus of the
// data memory arbiter. The arbiter connects through the slave modport; the
// requesters and the memory connect through the master modport.
interface dmem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_valid;
    logic          resp0_err;
    logic [DW-1:0] resp0_rdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_valid;
    logic          resp1_err;
    logic [DW-1:0] resp1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_memwrite;
    logic          mem_memread;
    logic [DW-1:0] mem_read_data;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_err, resp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_err, resp1_rdata,
        output mem_addr, mem_write_data, mem_memwrite, mem_memread,
        input  mem_read_data
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_err, resp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_err, resp1_rdata,
        input  mem_addr, mem_write_data, mem_memwrite, mem_memread,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data
// memory with synchronous write and 1-cycle registered read.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | arbitrate, accept one request, check its address
//   ACCESS | drive one memory strobe (read or write) for a single cycle
//   RESP   | one-cycle response pulse on the granted port
module dmem_arbiter #(
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int DEPTH = 256
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state, state_nxt;
    logic          last_grant, last_grant_nxt;

    logic          grant0, grant1;
    logic          ready0, ready1;
    logic          accept, accept_port;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_legal;

    logic          lat_port, lat_port_nxt;
    logic          lat_load, lat_load_nxt;

    logic [AW-1:0] mem_addr_q, mem_addr_nxt;
    logic [DW-1:0] mem_wdata_q, mem_wdata_nxt;
    logic          mem_write_q, mem_write_nxt;
    logic          mem_read_q, mem_read_nxt;

    logic [1:0]    resp_valid_q, resp_valid_nxt;
    logic [1:0]    resp_err_q, resp_err_nxt;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic [DW-1:0] resp_data;

    // Arbitration winner and readies: only in IDLE, alternating on contention.
    always_comb begin
        grant0      = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1      = bus.req1_valid && (!bus.req0_valid || !last_grant);
        ready0      = (state == IDLE) && grant0;
        ready1      = (state == IDLE) && grant1;
        accept      = ready0 || ready1;
        accept_port = ready1;
        sel_write   = accept_port ? bus.req1_write : bus.req0_write;
        sel_addr    = accept_port ? bus.req1_addr  : bus.req0_addr;
        sel_wdata   = accept_port ? bus.req1_wdata : bus.req0_wdata;
        sel_legal   = sel_addr < DEPTH_W;
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lat_port_nxt   = lat_port;
        lat_load_nxt   = lat_load;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        mem_write_nxt  = 1'b0;
        mem_read_nxt   = 1'b0;
        resp_valid_nxt = 2'b00;
        resp_err_nxt   = resp_err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    last_grant_nxt = accept_port;
                    lat_port_nxt   = accept_port;
                    lat_load_nxt   = !sel_write && sel_legal;
                    if (sel_legal) begin
                        state_nxt     = ACCESS;
                        mem_addr_nxt  = sel_addr;
                        mem_wdata_nxt = sel_wdata;
                        mem_write_nxt = sel_write;
                        mem_read_nxt  = !sel_write;
                    end else begin
                        // Illegal address never reaches memory.
                        state_nxt                   = RESP;
                        resp_valid_nxt[accept_port] = 1'b1;
                        resp_err_nxt[accept_port]   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_nxt                = RESP;
                resp_valid_nxt[lat_port] = 1'b1;
                resp_err_nxt[lat_port]   = 1'b0;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant history, latched transaction attributes and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= 1'b1;
            lat_port     <= 1'b0;
            lat_load     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 2'b00;
        end else begin
            last_grant   <= last_grant_nxt;
            lat_port     <= lat_port_nxt;
            lat_load     <= lat_load_nxt;
            mem_addr_q   <= mem_addr_nxt;
            mem_wdata_q  <= mem_wdata_nxt;
            mem_write_q  <= mem_write_nxt;
            mem_read_q   <= mem_read_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_err_q   <= resp_err_nxt;
        end
    end

    // The memory's read register only becomes valid in RESP, so the load data
    // is forwarded from it during RESP and captured for holding afterwards.
    assign resp_data = lat_load ? bus.mem_read_data : '0;

    // Response data hold registers, updated at the end of each RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == RESP) begin
            if (lat_port) begin
                rdata1_q <= resp_data;
            end else begin
                rdata0_q <= resp_data;
            end
        end
    end

    assign bus.resp0_rdata    = (state == RESP && !lat_port) ? resp_data : rdata0_q;
    assign bus.resp1_rdata    = (state == RESP &&  lat_port) ? resp_data : rdata1_q;
    assign bus.resp0_valid    = resp_valid_q[0];
    assign bus.resp1_valid    = resp_valid_q[1];
    assign bus.resp0_err      = resp_err_q[0];
    assign bus.resp1_err      = resp_err_q[1];
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_memwrite   = mem_write_q;
    assign bus.mem_memread    = mem_read_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 256-word memory.
module tb_dmem_arbiter;
    logic clk;
    logic rst;

    dmem_arbiter_if #(.AW(64), .DW(64)) bus ();

    dmem_arbiter #(.AW(64), .DW(64), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          port;
        bit          err;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    int          last_acc = -1;
    bit          chk_gap = 0;
    logic [63:0] mem_arr [0:255];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.mem_memwrite) mem_arr[bus.mem_addr[7:0]] <= bus.mem_write_data;
        if (bus.mem_memread)  bus.mem_read_data <= mem_arr[bus.mem_addr[7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_memwrite) wr_cnt++;
            if (bus.mem_memread)  rd_cnt++;
            if (bus.resp0_valid || bus.resp1_valid) begin
                if (bus.resp0_valid && bus.resp1_valid)
                    check("resp_both_ports", 64'd1, 64'd0);
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {63'd0, bus.resp1_valid}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_port", bus.resp1_valid ? 64'd1 : 64'd0, 64'(e.port));
                    check("resp_err", bus.resp1_valid ? {63'd0, bus.resp1_err} : {63'd0, bus.resp0_err},
                          {63'd0, e.err});
                    check("resp_rdata", bus.resp1_valid ? bus.resp1_rdata : bus.resp0_rdata, e.rdata);
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic set_req(input int p, input bit v, input bit wr, input logic [63:0] a,
                           input logic [63:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // Issues n identical requests on port p, holding valid between them.
    task automatic port_send(input int p, input bit wr, input logic [63:0] a, input logic [63:0] d,
                             input int n, input bit eerr, input logic [63:0] erd);
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 0;
            set_req(p, 1'b1, wr, a, d);
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                got = (p == 0) ? bus.req0_ready : bus.req1_ready;
            end
            if (!got) begin
                check("accept_timeout", 64'(p), 64'hDEAD);
                set_req(p, 1'b0, 1'b0, '0, '0);
                return;
            end
            if (grant_q.size() == 0) check("grant_unexpected", 64'(p), 64'hFFFF);
            else check("grant_order", 64'(p), 64'(grant_q.pop_front()));
            if (chk_gap && last_acc != -1) check("accept_gap", 64'(cyc - last_acc), 64'd3);
            last_acc = cyc;
            exp_q.push_back('{port: p, err: eerr, rdata: erd, cyc: cyc + (eerr ? 1 : 2)});
            @(posedge clk);
            #1;
            if (k == n - 1) set_req(p, 1'b0, 1'b0, '0, '0);
            if (!eerr) begin
                @(negedge clk);
                check("access_addr", bus.mem_addr, a);
                check("access_strobes", {62'd0, bus.mem_memwrite, bus.mem_memread},
                      wr ? 64'd2 : 64'd1);
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr0, rd0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 64'(i);
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_strobes", {62'd0, bus.mem_memwrite, bus.mem_memread}, 64'd0);
        check("rst_resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
        check("rst_resp_err", {62'd0, bus.resp1_err, bus.resp0_err}, 64'd0);
        check("rst_rdata0", bus.resp0_rdata, 64'd0);
        check("rst_ready_idle", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        @(posedge clk);
        #1;

        // Port 0 load addr 5
        grant_q.push_back(0);
        port_send(0, 1'b0, 64'd5, 64'd0, 1, 1'b0, 64'd5);
        drain("drain_load5");

        // Port 1 store then load addr 10
        wr0 = wr_cnt;
        grant_q.push_back(1);
        port_send(1, 1'b1, 64'd10, 64'hDEAD_BEEF, 1, 1'b0, 64'd0);
        drain("drain_store10");
        check("store_pulse_count", 64'(wr_cnt - wr0), 64'd1);
        grant_q.push_back(1);
        port_send(1, 1'b0, 64'd10, 64'd0, 1, 1'b0, 64'hDEAD_BEEF);
        drain("drain_load10");

        // Both ports contend continuously: grants alternate
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(0); grant_q.push_back(1);
        chk_gap = 1; last_acc = -1;
        fork
            port_send(0, 1'b0, 64'd1, 64'd0, 2, 1'b0, 64'd1);
            port_send(1, 1'b0, 64'd2, 64'd0, 2, 1'b0, 64'd2);
        join
        chk_gap = 0;
        drain("drain_alternate");

        // Out-of-range address
        wr0 = wr_cnt; rd0 = rd_cnt;
        grant_q.push_back(0);
        port_send(0, 1'b0, 64'd256, 64'd0, 1, 1'b1, 64'd0);
        drain("drain_err256");
        check("err_no_strobes", 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
        grant_q.push_back(1);
        port_send(1, 1'b1, 64'h8000_0000_0000_0005, 64'd7, 1, 1'b1, 64'd0);
        drain("drain_err_high");

        // Reset during ACCESS of a port 1 store
        begin
            bit got;
            got = 0;
            set_req(1, 1'b1, 1'b1, 64'd20, 64'h55);
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                got = bus.req1_ready;
            end
            check("rst_case_accept", {63'd0, got}, 64'd1);
            @(posedge clk);
            #1 set_req(1, 1'b0, 1'b0, '0, '0);
            #1 check("rst_case_write_on", {63'd0, bus.mem_memwrite}, 64'd1);
            rst = 1'b1;
            #1;
            check("rst_async_strobes", {62'd0, bus.mem_memwrite, bus.mem_memread}, 64'd0);
            check("rst_async_resp", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        grant_q.push_back(0); grant_q.push_back(1);
        fork
            port_send(0, 1'b0, 64'd3, 64'd0, 1, 1'b0, 64'd3);
            port_send(1, 1'b0, 64'd4, 64'd0, 1, 1'b0, 64'd4);
        join
        drain("drain_after_rst");

        // Port 1 arrives during port 0 ACCESS, accepted at T+3
        grant_q.push_back(0); grant_q.push_back(1);
        chk_gap = 1; last_acc = -1;
        fork
            port_send(0, 1'b0, 64'd7, 64'd0, 1, 1'b0, 64'd7);
            begin
                @(posedge clk);
                #1 set_req(1, 1'b1, 1'b1, 64'd30, 64'h1234);
                @(negedge clk);
                check("late_ready_access", {63'd0, bus.req1_ready}, 64'd0);
                @(negedge clk);
                check("late_ready_resp", {63'd0, bus.req1_ready}, 64'd0);
                port_send(1, 1'b1, 64'd30, 64'h1234, 1, 1'b0, 64'd0);
            end
        join
        chk_gap = 0;
        drain("drain_late");
        grant_q.push_back(0);
        port_send(0, 1'b0, 64'd30, 64'd0, 1, 1'b0, 64'h1234);
        drain("drain_readback30");

        check("grants_consumed", 64'(grant_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
